zstd_hash_task_dispatcher: RTL

- Upstream feeder for the tree-walker match-search engine.
- Consumes a raw byte stream and forms a 4-byte sliding window, which is the minimum match length.
- Hashes each window with a multiplicative hash and queues (hash, offset) tasks in a small FIFO.
- Issues tasks to the walker over its task_valid/ready handshake, then signals completion when the stream is exhausted and all tasks are issued.

---
 rtl/zstd_hash_task_dispatcher.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/zstd_hash_task_dispatcher.sv
// Byte-stream front end for the match-search walker: slides a 4-byte window over
// the input, hashes every full window and queues (hash, offset) tasks in a FWFT FIFO.
module zstd_hash_task_dispatcher #(
  parameter int unsigned HASH_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] HASH_MULT  = 32'h9E3779B1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_offset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  task_valid,
  output logic [HASH_WIDTH-1:0] task_hash,
  output logic [ADDR_WIDTH-1:0] task_offset,
  input  logic                  walker_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] tasks_issued
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN
  } state_e;

  state_e                state_q, state_d;
  // Only the three newest bytes are history; the fourth is always the incoming byte.
  logic [23:0]           window_q, window_d;
  logic [2:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0] pos_q, pos_d;
  logic [ADDR_WIDTH-1:0] issued_q, issued_d;
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
  logic                  done_q, done_d;

  logic [HASH_WIDTH-1:0] hash_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] off_mem  [FIFO_DEPTH];

  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [31:0]           new_window;
  logic [31:0]           prod;
  logic [ADDR_WIDTH-1:0] push_offset;

  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign accept      = (state_q == ST_ACTIVE) && in_valid && !fifo_full;
  assign push        = accept && (byte_cnt_q >= 3'd3);
  assign pop         = !fifo_empty && walker_ready;
  assign new_window  = {window_q, in_data};
  assign prod        = new_window * HASH_MULT;
  assign push_offset = pos_q - ADDR_WIDTH'(3);

  assign in_ready     = (state_q == ST_ACTIVE) && !fifo_full;
  assign task_valid   = !fifo_empty;
  assign task_hash    = fifo_empty ? '0 : hash_mem[rd_ptr_q[PTR_W-1:0]];
  assign task_offset  = fifo_empty ? '0 : off_mem[rd_ptr_q[PTR_W-1:0]];
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign tasks_issued = issued_q;

  always_comb begin
    state_d    = state_q;
    window_d   = window_q;
    byte_cnt_d = byte_cnt_q;
    pos_d      = pos_q;
    issued_d   = issued_q + ADDR_WIDTH'(pop);
    wr_ptr_d   = wr_ptr_q + {{PTR_W{1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{PTR_W{1'b0}}, pop};
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_ACTIVE;
          pos_d      = base_offset;
          window_d   = '0;
          byte_cnt_d = '0;
          issued_d   = '0;
        end
      end
      ST_ACTIVE: begin
        if (accept) begin
          window_d = new_window[23:0];
          pos_d    = pos_q + ADDR_WIDTH'(1);
          if (byte_cnt_q < 3'd4) begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
          if (in_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      window_q   <= '0;
      byte_cnt_q <= '0;
      pos_q      <= '0;
      issued_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      window_q   <= window_d;
      byte_cnt_q <= byte_cnt_d;
      pos_q      <= pos_d;
      issued_q   <= issued_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      done_q     <= done_d;
    end
  end

  // Storage needs no reset: entries are only observable between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      hash_mem[wr_ptr_q[PTR_W-1:0]] <= prod[31 -: HASH_WIDTH];
      off_mem[wr_ptr_q[PTR_W-1:0]]  <= push_offset;
    end
  end

endmodule
